ili934x_responder: RTL and testbench

Device-side model of the ILI9341 8080-8 write interface. It passively samples the panel bus our LCD driver produces, decodes commands and parameters, and tracks the column/page window and the display/sleep/format registers. It converts MEMORY WRITE (2Ch) byte pairs into addressed RGB565 framebuffer writes. It sits in simulation benches and in FPGA loopback builds, where it drives an on-chip framebuffer in place of a physical panel.

---
 rtl/ili934x_responder_if.sv | 18 +
 rtl/ili934x_responder.sv | 178 +++++++++++++++++
 tb/tb_ili934x_responder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ili934x_responder_if.sv
// ILI9341 8080-8 write bus as seen between the LCD driver and the panel.
// The driver (or a bench) is the master; the responder samples as slave.
interface ili934x_responder_if;
    logic       lcd_cs_n;
    logic       lcd_rd_n;
    logic       lcd_rst_n;
    logic       lcd_dc;
    logic       lcd_wr_n;
    logic [7:0] lcd_d;

    modport master (
        output lcd_cs_n, lcd_rd_n, lcd_rst_n, lcd_dc, lcd_wr_n, lcd_d
    );

    modport slave (
        input lcd_cs_n, lcd_rd_n, lcd_rst_n, lcd_dc, lcd_wr_n, lcd_d
    );
endinterface

// File: rtl/ili934x_responder.sv
// Device-side ILI9341 write-interface model: samples the panel bus,
// decodes commands/parameters, tracks the address window and the
// control registers, and turns MEMORY WRITE byte pairs into RGB565
// framebuffer writes.
module ili934x_responder #(
    parameter int X_RES  = 240,
    parameter int Y_RES  = 320,
    parameter int ADDR_W = $clog2(X_RES * Y_RES)
) (
    input  logic              clk,
    input  logic              rst_n,
    ili934x_responder_if.slave bus,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic [7:0]        colmod,
    output logic [7:0]        madctl,
    output logic              sleep_out,
    output logic              disp_on,
    output logic              fmt_err
);

    typedef enum logic [2:0] {
        IDLE, IGNORE, CASET, PASET, RAMWR, COLMOD, MADCTL
    } state_t;

    localparam logic [15:0] EC_DEF = 16'(X_RES - 1);
    localparam logic [15:0] EP_DEF = 16'(Y_RES - 1);

    // Reads are not supported; the strobe is deliberately unused.
    logic unused_rd;
    assign unused_rd = bus.lcd_rd_n;

    logic       wr_s1, wr_s2, wr_s3, cs_s1, cs_s2, dc_s1, dc_s2;
    logic       lrst_s1, lrst_s2;
    logic [7:0] d_s1, d_s2;

    // Two-flop synchronizers for every bus pin, plus an edge-detect copy of wr_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_s1   <= 1'b1; wr_s2 <= 1'b1; wr_s3 <= 1'b1;
            cs_s1   <= 1'b1; cs_s2 <= 1'b1;
            dc_s1   <= 1'b0; dc_s2 <= 1'b0;
            d_s1    <= '0;   d_s2  <= '0;
            lrst_s1 <= 1'b0; lrst_s2 <= 1'b0;
        end else begin
            wr_s1   <= bus.lcd_wr_n;  wr_s2 <= wr_s1; wr_s3 <= wr_s2;
            cs_s1   <= bus.lcd_cs_n;  cs_s2 <= cs_s1;
            dc_s1   <= bus.lcd_dc;    dc_s2 <= dc_s1;
            d_s1    <= bus.lcd_d;     d_s2  <= d_s1;
            lrst_s1 <= bus.lcd_rst_n; lrst_s2 <= lrst_s1;
        end
    end

    // A byte is taken once per WR rising edge while selected.
    logic stb, cmd_stb, data_stb, soft_rst;
    assign stb      = !wr_s3 && wr_s2 && !cs_s2;
    assign cmd_stb  = stb && !dc_s2 && lrst_s2;
    assign data_stb = stb &&  dc_s2 && lrst_s2;
    assign soft_rst = !lrst_s2 || (cmd_stb && d_s2 == 8'h01);

    state_t state_q, state_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next state: every command byte re-targets the parameter parser.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state_q;
        if (!lrst_s2) begin
            state_nxt = IDLE;
        end else if (cmd_stb) begin
            case (d_s2)
                8'h2A:   state_nxt = CASET;
                8'h2B:   state_nxt = PASET;
                8'h2C:   state_nxt = RAMWR;
                8'h3A:   state_nxt = COLMOD;
                8'h36:   state_nxt = MADCTL;
                8'h01, 8'h11, 8'h10, 8'h29, 8'h28: state_nxt = IDLE;
                default: state_nxt = IGNORE;
            endcase
        end
    end

    logic [15:0] sc, ec, sp, ep, cur_x, cur_y;
    logic [7:0]  p0, p1, p2, hi;
    logic [2:0]  idx;
    logic        phase;
    logic        in_range;
    logic [ADDR_W-1:0] lin_addr;

    assign in_range = ({16'h0, cur_x} < 32'(X_RES)) && ({16'h0, cur_y} < 32'(Y_RES));
    assign lin_addr = ADDR_W'(32'(cur_y) * 32'(X_RES) + 32'(cur_x));

    // Registers, window, parameter collection and pixel emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colmod <= 8'h66; madctl <= 8'h00; sleep_out <= 1'b0; disp_on <= 1'b0;
            fmt_err <= 1'b0; sc <= '0; ec <= EC_DEF; sp <= '0; ep <= EP_DEF;
            pix_we <= 1'b0; cmd_valid <= 1'b0; pix_addr <= '0; pix_data <= '0;
            cmd_code <= 8'h00; cur_x <= '0; cur_y <= '0;
            p0 <= '0; p1 <= '0; p2 <= '0; hi <= '0; idx <= '0; phase <= 1'b0;
        end else if (soft_rst) begin
            // Panel reset pin holds everything at defaults; SWRESET still reports itself.
            colmod <= 8'h66; madctl <= 8'h00; sleep_out <= 1'b0; disp_on <= 1'b0;
            fmt_err <= 1'b0; sc <= '0; ec <= EC_DEF; sp <= '0; ep <= EP_DEF;
            pix_we <= 1'b0; pix_addr <= '0; pix_data <= '0;
            idx <= '0; phase <= 1'b0;
            cmd_valid <= lrst_s2;
            cmd_code  <= lrst_s2 ? 8'h01 : 8'h00;
        end else begin
            pix_we    <= 1'b0;
            cmd_valid <= 1'b0;
            if (cmd_stb) begin
                cmd_valid <= 1'b1;
                cmd_code  <= d_s2;
                idx       <= '0;
                phase     <= 1'b0;
                case (d_s2)
                    8'h2C: begin cur_x <= sc; cur_y <= sp; end
                    8'h11: sleep_out <= 1'b1;
                    8'h10: sleep_out <= 1'b0;
                    8'h29: disp_on   <= 1'b1;
                    8'h28: disp_on   <= 1'b0;
                    default: ;
                endcase
            end else if (data_stb) begin
                if (idx < 3'd4) idx <= idx + 3'd1;
                case (state_q)
                    COLMOD: if (idx == 3'd0) colmod <= d_s2;
                    MADCTL: if (idx == 3'd0) madctl <= d_s2;
                    CASET, PASET: begin
                        case (idx)
                            3'd0: p0 <= d_s2;
                            3'd1: p1 <= d_s2;
                            3'd2: p2 <= d_s2;
                            3'd3: begin
                                if (state_q == CASET) begin
                                    sc <= {p0, p1}; ec <= {p2, d_s2};
                                end else begin
                                    sp <= {p0, p1}; ep <= {p2, d_s2};
                                end
                            end
                            default: ;
                        endcase
                    end
                    RAMWR: begin
                        if (!phase) begin
                            hi    <= d_s2;
                            phase <= 1'b1;
                        end else begin
                            phase    <= 1'b0;
                            pix_data <= {hi, d_s2};
                            pix_addr <= lin_addr;
                            pix_we   <= in_range;
                            if (colmod[2:0] != 3'b101) fmt_err <= 1'b1;
                            if (cur_x >= ec) begin
                                cur_x <= sc;
                                cur_y <= (cur_y >= ep) ? sp : cur_y + 16'd1;
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ili934x_responder.sv
// Self-checking bench for ili934x_responder: register table, directed
// corner sequences and a randomized run against a window-index model.
module tb_ili934x_responder;
    localparam int XR = 240;
    localparam int YR = 320;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ili934x_responder_if bus();

    logic          pix_we, cmd_valid, sleep_out, disp_on, fmt_err;
    logic [AW-1:0] pix_addr;
    logic [15:0]   pix_data;
    logic [7:0]    cmd_code, colmod, madctl;

    ili934x_responder #(.X_RES(XR), .Y_RES(YR), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .colmod(colmod),
        .madctl(madctl), .sleep_out(sleep_out), .disp_on(disp_on),
        .fmt_err(fmt_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed framebuffer writes and command pulses.
    logic [32:0] act_q[$];
    logic [32:0] exp_q[$];
    int cmd_cnt = 0;
    always @(negedge clk) begin
        if (pix_we) act_q.push_back({pix_addr, pix_data});
        if (cmd_valid) cmd_cnt++;
    end

    // Reference model: window as a linear pixel index, mode = last command byte.
    logic [7:0] m_cmd, m_code, m_colmod, m_madctl, m_hi;
    logic [7:0] m_p[4];
    bit         m_sleep, m_disp, m_fmt, m_phase;
    longint     m_sc, m_ec, m_sp, m_ep, m_n;
    int         m_idx, m_cmds;

    task automatic m_defaults();
        m_colmod = 8'h66; m_madctl = 8'h00; m_sleep = 0; m_disp = 0; m_fmt = 0;
        m_sc = 0; m_ec = XR - 1; m_sp = 0; m_ep = YR - 1; m_cmd = 8'h00;
        m_phase = 0; m_idx = 0; m_n = 0;
    endtask

    task automatic m_pixel(input logic [7:0] lo);
        longint w, h, x, y, a;
        w = (m_ec >= m_sc) ? m_ec - m_sc + 1 : 1;
        h = (m_ep >= m_sp) ? m_ep - m_sp + 1 : 1;
        x = m_sc + (m_n % w);
        y = m_sp + ((m_n / w) % h);
        m_n = (m_n + 1) % (w * h);
        if (m_colmod[2:0] != 3'b101) m_fmt = 1;
        if (x < XR && y < YR) begin
            a = (y * XR + x) % (longint'(1) << AW);
            exp_q.push_back({a[AW-1:0], m_hi, lo});
        end
    endtask

    task automatic m_byte(input logic dc, input logic [7:0] d);
        if (!dc) begin
            m_cmds++; m_code = d; m_cmd = d; m_idx = 0; m_phase = 0;
            case (d)
                8'h01: m_defaults();
                8'h11: m_sleep = 1;
                8'h10: m_sleep = 0;
                8'h29: m_disp = 1;
                8'h28: m_disp = 0;
                8'h2C: m_n = 0;
                default: ;
            endcase
        end else begin
            case (m_cmd)
                8'h3A: if (m_idx == 0) m_colmod = d;
                8'h36: if (m_idx == 0) m_madctl = d;
                8'h2A, 8'h2B: begin
                    if (m_idx < 4) m_p[m_idx] = d;
                    if (m_idx == 3) begin
                        if (m_cmd == 8'h2A) begin m_sc = {m_p[0], m_p[1]}; m_ec = {m_p[2], m_p[3]}; end
                        else                begin m_sp = {m_p[0], m_p[1]}; m_ep = {m_p[2], m_p[3]}; end
                    end
                end
                8'h2C: begin
                    if (!m_phase) begin m_hi = d; m_phase = 1; end
                    else begin m_pixel(d); m_phase = 0; end
                end
                default: ;
            endcase
            m_idx++;
        end
    endtask

    // One bus byte: WR low 2 clk, high 3 clk, data held throughout.
    task automatic drive(input logic dc, input logic [7:0] d, input logic cs_n);
        @(negedge clk);
        bus.lcd_dc = dc; bus.lcd_d = d; bus.lcd_cs_n = cs_n;
        @(negedge clk); bus.lcd_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.lcd_wr_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic dc, input logic [7:0] d);
        if (bus.lcd_rst_n) m_byte(dc, d);
        drive(dc, d, 1'b0);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic hard_reset();
        bus.lcd_cs_n = 1'b1; bus.lcd_rd_n = 1'b1; bus.lcd_rst_n = 1'b1;
        bus.lcd_dc = 1'b0; bus.lcd_wr_n = 1'b1; bus.lcd_d = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        m_defaults(); m_code = 8'h00; m_cmds = 0;
        act_q.delete(); exp_q.delete(); cmd_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] code;
        bit         has_p;
        logic [7:0] p;
        logic [7:0] colmod;
        logic [7:0] madctl;
        bit         sleep;
        bit         disp;
    } reg_vec_t;

    reg_vec_t tbl[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cumulative register-command vectors applied from reset.
        tbl[0]  = '{8'h3A, 1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h36, 1'b1, 8'h48, 8'h55, 8'h48, 1'b0, 1'b0};
        tbl[2]  = '{8'h11, 1'b0, 8'h00, 8'h55, 8'h48, 1'b1, 1'b0};
        tbl[3]  = '{8'h29, 1'b0, 8'h00, 8'h55, 8'h48, 1'b1, 1'b1};
        tbl[4]  = '{8'h28, 1'b0, 8'h00, 8'h55, 8'h48, 1'b1, 1'b0};
        tbl[5]  = '{8'h10, 1'b0, 8'h00, 8'h55, 8'h48, 1'b0, 1'b0};
        tbl[6]  = '{8'h11, 1'b0, 8'h00, 8'h55, 8'h48, 1'b1, 1'b0};
        tbl[7]  = '{8'h29, 1'b0, 8'h00, 8'h55, 8'h48, 1'b1, 1'b1};
        tbl[8]  = '{8'h3A, 1'b1, 8'h66, 8'h66, 8'h48, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, 1'b1, 8'h12, 8'h66, 8'h48, 1'b1, 1'b1};
        tbl[10] = '{8'h01, 1'b0, 8'h00, 8'h66, 8'h00, 1'b0, 1'b0};

        // Reset values.
        hard_reset();
        check("rst_pix_we", pix_we, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_cmd_code", cmd_code, 8'h00);
        check("rst_colmod", colmod, 8'h66);
        check("rst_madctl", madctl, 8'h00);
        check("rst_sleep", sleep_out, 0);
        check("rst_disp", disp_on, 0);
        check("rst_fmt_err", fmt_err, 0);

        // Register command table.
        foreach (tbl[i]) begin
            send(1'b0, tbl[i].code);
            if (tbl[i].has_p) send(1'b1, tbl[i].p);
            settle();
            check($sformatf("tbl%0d_colmod", i), colmod, tbl[i].colmod);
            check($sformatf("tbl%0d_madctl", i), madctl, tbl[i].madctl);
            check($sformatf("tbl%0d_sleep", i), sleep_out, tbl[i].sleep);
            check($sformatf("tbl%0d_disp", i), disp_on, tbl[i].disp);
            check($sformatf("tbl%0d_code", i), cmd_code, tbl[i].code);
            check($sformatf("tbl%0d_fmt", i), fmt_err, 0);
        end

        // Window + pixels with wrap.
        hard_reset();
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h0B);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h14); send(1, 8'h00); send(1, 8'h14);
        send(0, 8'h2C);
        send(1, 8'hF8); send(1, 8'h00); send(1, 8'h07); send(1, 8'hE0); send(1, 8'h00); send(1, 8'h1F);
        settle();
        check("win_count", act_q.size(), 3);
        if (act_q.size() == 3) begin
            check("win_w0", act_q[0], {17'd4810, 16'hF800});
            check("win_w1", act_q[1], {17'd4811, 16'h07E0});
            check("win_w2", act_q[2], {17'd4810, 16'h001F});
        end
        check("win_last_addr", pix_addr, 17'd4810);

        // Aborted CASET keeps the default window.
        hard_reset();
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h05);
        send(0, 8'h2C); send(1, 8'hFF); send(1, 8'hFF);
        settle();
        check("abort_count", act_q.size(), 1);
        if (act_q.size() == 1) check("abort_w0", act_q[0], {17'd0, 16'hFFFF});

        // Default EC=239: pixel 240 wraps to the next row.
        hard_reset();
        send(0, 8'h3A); send(1, 8'h55); send(0, 8'h2C);
        for (int i = 0; i < 241; i++) begin send(1, 8'(i >> 8)); send(1, 8'(i)); end
        settle();
        check("row_count", act_q.size(), 241);
        if (act_q.size() == 241) begin
            check("row_w239", act_q[239], {17'd239, 16'd239});
            check("row_w240", act_q[240], {17'd240, 16'd240});
        end
        check("row_fmt", fmt_err, 0);

        // Out-of-range window and format error.
        hard_reset();
        send(0, 8'h2A); send(1, 8'h01); send(1, 8'h00); send(1, 8'h01); send(1, 8'h00);
        send(0, 8'h2C); send(1, 8'hAA); send(1, 8'hBB);
        settle();
        check("oor_writes", act_q.size(), 0);
        check("oor_fmt_err", fmt_err, 1);
        check("oor_cmd_pulses", cmd_cnt, 2);

        // Panel reset held low gates everything.
        hard_reset();
        bus.lcd_rst_n = 1'b0;
        repeat (4) @(negedge clk);
        send(0, 8'h3A); send(1, 8'h55);
        send(0, 8'h2C); send(1, 8'hAA); send(1, 8'hBB);
        settle();
        check("lrst_writes", act_q.size(), 0);
        check("lrst_cmds", cmd_cnt, 0);
        check("lrst_colmod", colmod, 8'h66);
        bus.lcd_rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Chip select high gates everything.
        hard_reset();
        drive(0, 8'h3A, 1); drive(1, 8'h55, 1);
        drive(0, 8'h2C, 1); drive(1, 8'hAA, 1); drive(1, 8'hBB, 1);
        settle();
        check("cs_writes", act_q.size(), 0);
        check("cs_cmds", cmd_cnt, 0);
        check("cs_colmod", colmod, 8'h66);

        // Randomized traffic against the model.
        hard_reset();
        for (int t = 0; t < 80; t++) begin
            int kind, s, e, n;
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1: begin
                    s = (kind == 0) ? $urandom_range(0, 250) : $urandom_range(0, 330);
                    e = ($urandom_range(0, 4) == 0 && s > 0) ? s - 1 : s + $urandom_range(0, 3);
                    n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 4;
                    send(0, (kind == 0) ? 8'h2A : 8'h2B);
                    if (n > 0) send(1, 8'(s >> 8));
                    if (n > 1) send(1, 8'(s));
                    if (n > 2) send(1, 8'(e >> 8));
                    if (n > 3) send(1, 8'(e));
                end
                2: begin
                    send(0, 8'h2C);
                    n = $urandom_range(1, 14);
                    for (int i = 0; i < n; i++) send(1, 8'($urandom));
                end
                3: begin
                    send(0, ($urandom_range(0, 1) != 0) ? 8'h3A : 8'h36);
                    send(1, ($urandom_range(0, 2) != 0) ? 8'h55 : 8'($urandom));
                end
                4: begin
                    case ($urandom_range(0, 3))
                        0: send(0, 8'h11);
                        1: send(0, 8'h10);
                        2: send(0, 8'h29);
                        default: send(0, 8'h28);
                    endcase
                end
                5: drive(1, 8'($urandom), 1);
                default: begin
                    send(0, 8'hB1);
                    send(1, 8'($urandom));
                end
            endcase
        end
        settle();
        check("rnd_write_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("rnd_write%0d", i), act_q[i], exp_q[i]);
        check("rnd_cmd_count", cmd_cnt, m_cmds);
        check("rnd_cmd_code", cmd_code, m_code);
        check("rnd_colmod", colmod, m_colmod);
        check("rnd_madctl", madctl, m_madctl);
        check("rnd_sleep", sleep_out, m_sleep);
        check("rnd_disp", disp_on, m_disp);
        check("rnd_fmt_err", fmt_err, m_fmt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
